ring_step_monitor: RTL and testbench



---
 rtl/ring_pkg.sv | 35 +++
 rtl/ring_sync.sv | 25 ++
 rtl/ring_step_monitor.sv | 158 +++++++++++++++
 tb/tb_ring_step_monitor.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ring_pkg.sv
// Shared encodings and pattern helpers for the ring step monitor.
package ring_pkg;

  localparam int unsigned RING_MAX_W = 32;

  localparam logic [1:0] ACQUIRE = 2'd0;
  localparam logic [1:0] TRACK   = 2'd1;
  localparam logic [1:0] FAULT   = 2'd2;

  localparam logic [1:0] FC_NONE       = 2'b00;
  localparam logic [1:0] FC_NOT_ONEHOT = 2'b01;
  localparam logic [1:0] FC_JUMP       = 2'b10;

  function automatic logic is_onehot(input logic [RING_MAX_W-1:0] v);
    return (v != '0) && ((v & (v - RING_MAX_W'(1))) == '0);
  endfunction

  // Rotate left by one within the low w bits; upper bits of v must be zero.
  function automatic logic [RING_MAX_W-1:0] rotl1(input logic [RING_MAX_W-1:0] v,
                                                  input int unsigned w);
    logic [RING_MAX_W-1:0] mask;
    mask = (w >= RING_MAX_W) ? '1 : ((RING_MAX_W'(1) << w) - RING_MAX_W'(1));
    return ((v << 1) | (v >> (w - 1))) & mask;
  endfunction

  function automatic int unsigned onehot_to_idx(input logic [RING_MAX_W-1:0] v);
    int unsigned idx;
    idx = 0;
    for (int unsigned i = 0; i < RING_MAX_W; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/ring_sync.sv
// Multi-stage synchronizer for a bus of independent asynchronous bits, reset to zero.
module ring_sync #(
  parameter int unsigned WIDTH  = 4,
  parameter int unsigned STAGES = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out
);

  logic [WIDTH-1:0] sync_q [STAGES];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < int'(STAGES); i++) sync_q[i] <= '0;
    end else begin
      sync_q[0] <= async_in;
      for (int i = 1; i < int'(STAGES); i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign sync_out = sync_q[STAGES-1];

endmodule

// File: rtl/ring_step_monitor.sv
// Validates and tracks a one-hot ring counter crossing into the board clock domain.
// Optional glitch filter on the synchronised pattern: RING_STABLE_FILTER_EN.
module ring_step_monitor
  import ring_pkg::*;
#(
  parameter int unsigned WIDTH         = 4,
  parameter int unsigned CNT_W         = 8,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned STABLE_CYCLES = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic [WIDTH-1:0]         ring_in,
  input  logic                     clear_err,
  output logic [$clog2(WIDTH)-1:0] pos,
  output logic                     locked,
  output logic                     step_pulse,
  output logic                     rotation_pulse,
  output logic [CNT_W-1:0]         rev_count,
  output logic                     fault,
  output logic [1:0]               fault_code
);

  localparam int unsigned PosW = $clog2(WIDTH);

  logic [WIDTH-1:0] sample;
  logic [WIDTH-1:0] eval_pat;
  logic [WIDTH-1:0] prev_q;

  ring_sync #(
    .WIDTH  (WIDTH),
    .STAGES (SYNC_STAGES)
  ) u_sync (
    .clock    (clock),
    .reset    (reset),
    .async_in (ring_in),
    .sync_out (sample)
  );

`ifdef RING_STABLE_FILTER_EN
  localparam int unsigned CntW = $clog2(STABLE_CYCLES + 1);

  logic [WIDTH-1:0] cand_q;
  logic [WIDTH-1:0] accepted_q;
  logic [CntW-1:0]  stable_cnt_q;

  // A candidate is promoted once it has been seen STABLE_CYCLES times in a row.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      cand_q       <= '0;
      accepted_q   <= '0;
      stable_cnt_q <= '0;
    end else if (sample != cand_q) begin
      cand_q       <= sample;
      stable_cnt_q <= CntW'(1);
    end else begin
      if (stable_cnt_q < CntW'(STABLE_CYCLES)) stable_cnt_q <= stable_cnt_q + CntW'(1);
      if (stable_cnt_q >= CntW'(STABLE_CYCLES - 1)) accepted_q <= cand_q;
    end
  end

  assign eval_pat = accepted_q;
`else
  logic unused_stable;
  assign unused_stable = (STABLE_CYCLES == 0);
  assign eval_pat      = sample;
`endif

  logic [RING_MAX_W-1:0] eval_ext;
  logic [RING_MAX_W-1:0] prev_ext;
  assign eval_ext = RING_MAX_W'(eval_pat);
  assign prev_ext = RING_MAX_W'(prev_q);

  logic [1:0]      state_q, state_d;
  logic [PosW-1:0] pos_q, pos_d, pos_inc;
  logic [CNT_W-1:0] rev_q, rev_d;
  logic [1:0]      code_q, code_d;
  logic            step_q, step_d;
  logic            rot_q, rot_d;
  logic            locked_q, fault_q;

  assign pos_inc = pos_q + PosW'(1);

  always_comb begin
    state_d = state_q;
    pos_d   = pos_q;
    rev_d   = rev_q;
    code_d  = code_q;
    step_d  = 1'b0;
    rot_d   = 1'b0;
    case (state_q)
      ACQUIRE: begin
        if (is_onehot(eval_ext)) begin
          state_d = TRACK;
          pos_d   = PosW'(onehot_to_idx(eval_ext));
        end
      end
      TRACK: begin
        if (eval_ext == prev_ext) begin
          state_d = TRACK;
        end else if (eval_ext == rotl1(prev_ext, WIDTH)) begin
          step_d = 1'b1;
          pos_d  = pos_inc;
          if (pos_inc == '0) begin
            rot_d = 1'b1;
            rev_d = rev_q + CNT_W'(1);
          end
        end else begin
          state_d = FAULT;
          code_d  = is_onehot(eval_ext) ? FC_JUMP : FC_NOT_ONEHOT;
        end
      end
      FAULT: begin
        if (clear_err) begin
          state_d = ACQUIRE;
          code_d  = FC_NONE;
        end
      end
      default: begin
        state_d = ACQUIRE;
        code_d  = FC_NONE;
      end
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q  <= ACQUIRE;
      prev_q   <= '0;
      pos_q    <= '0;
      rev_q    <= '0;
      code_q   <= FC_NONE;
      step_q   <= 1'b0;
      rot_q    <= 1'b0;
      locked_q <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      prev_q   <= eval_pat;
      pos_q    <= pos_d;
      rev_q    <= rev_d;
      code_q   <= code_d;
      step_q   <= step_d;
      rot_q    <= rot_d;
      locked_q <= (state_d == TRACK);
      fault_q  <= (state_d == FAULT);
    end
  end

  assign pos            = pos_q;
  assign locked         = locked_q;
  assign step_pulse     = step_q;
  assign rotation_pulse = rot_q;
  assign rev_count      = rev_q;
  assign fault          = fault_q;
  assign fault_code     = code_q;

endmodule

// File: tb/tb_ring_step_monitor.sv
// Directed self-checking bench for ring_step_monitor (4-position ring, 4-bit rotation counter).
module tb_ring_step_monitor;

`ifdef RING_STABLE_FILTER_EN
  localparam int LAT = 3 + 4;
`else
  localparam int LAT = 3;
`endif

  logic       clock = 1'b0;
  logic       reset;
  logic [3:0] ring_in;
  logic       clear_err;
  logic [1:0] pos;
  logic       locked;
  logic       step_pulse;
  logic       rotation_pulse;
  logic [3:0] rev_count;
  logic       fault;
  logic [1:0] fault_code;

  int n_checks = 0;
  int n_fail   = 0;
  int step_seen;
  int rot_seen;

  ring_step_monitor #(
    .WIDTH         (4),
    .CNT_W         (4),
    .SYNC_STAGES   (2),
    .STABLE_CYCLES (4)
  ) dut (
    .clock          (clock),
    .reset          (reset),
    .ring_in        (ring_in),
    .clear_err      (clear_err),
    .pos            (pos),
    .locked         (locked),
    .step_pulse     (step_pulse),
    .rotation_pulse (rotation_pulse),
    .rev_count      (rev_count),
    .fault          (fault),
    .fault_code     (fault_code)
  );

  always #5 clock = ~clock;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clock);
      #1;
      step_seen += int'(step_pulse);
      rot_seen  += int'(rotation_pulse);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    ring_in   = 4'b0001;
    clear_err = 1'b0;
    tick(2);
    reset     = 1'b0;
    step_seen = 0;
    rot_seen  = 0;
  endtask

  // Reset, then wait for 0001 to lock.
  task automatic reset_and_lock();
    do_reset();
    tick(LAT + 1);
  endtask

  task automatic test_reset();
    reset     = 1'b1;
    ring_in   = 4'b0000;
    clear_err = 1'b0;
    tick(2);
    n_checks++;
    if ({pos, locked, step_pulse, rotation_pulse, rev_count, fault, fault_code} !== 12'd0) begin
      n_fail++;
      $display("FAIL reset_values: got pos=%0d locked=%0b rev=%0d fault=%0b code=%0d, want all 0",
               pos, locked, rev_count, fault, fault_code);
    end
    ring_in   = 4'b0001;
    reset     = 1'b0;
    step_seen = 0;
    tick(LAT - 1);
    n_checks++;
    if (locked !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_too_early: got locked=%0b want 0", locked);
    end
    tick(1);
    n_checks++;
    if (locked !== 1'b1 || pos !== 2'd0) begin
      n_fail++;
      $display("FAIL lock_after_reset: got locked=%0b pos=%0d want locked=1 pos=0", locked, pos);
    end
    tick(3);
    n_checks++;
    if (step_seen !== 0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL lock_no_step: got steps=%0d fault=%0b want steps=0 fault=0", step_seen, fault);
    end
  endtask

  task automatic test_rotation();
    logic [3:0] pats [4];
    pats = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
    reset_and_lock();
    for (int k = 0; k < 4; k++) begin
      ring_in = pats[k];
      tick(LAT - 1);
      n_checks++;
      if (step_pulse !== 1'b0) begin
        n_fail++;
        $display("FAIL step_early[%0d]: got step=%0b want 0", k, step_pulse);
      end
      tick(1);
      n_checks++;
      if (step_pulse !== 1'b1 || pos !== 2'((k + 1) % 4) || rotation_pulse !== (k == 3)) begin
        n_fail++;
        $display("FAIL step[%0d]: got step=%0b pos=%0d rot=%0b want step=1 pos=%0d rot=%0b",
                 k, step_pulse, pos, rotation_pulse, (k + 1) % 4, k == 3);
      end
      tick(10 - LAT);
    end
    n_checks++;
    if (step_seen !== 4 || rot_seen !== 1 || rev_count !== 4'd1) begin
      n_fail++;
      $display("FAIL rotation_totals: got steps=%0d rots=%0d rev=%0d want 4 1 1",
               step_seen, rot_seen, rev_count);
    end
  endtask

  task automatic test_jump();
    reset_and_lock();
    ring_in = 4'b0010;
    tick(LAT + 2);
    step_seen = 0;
    ring_in   = 4'b1000;
    tick(LAT);
    n_checks++;
    if (fault !== 1'b1 || fault_code !== 2'b10 || pos !== 2'd1 || locked !== 1'b0 ||
        step_seen !== 0) begin
      n_fail++;
      $display("FAIL jump_fault: got fault=%0b code=%0d pos=%0d locked=%0b steps=%0d want 1 2 1 0 0",
               fault, fault_code, pos, locked, step_seen);
    end
    ring_in = 4'b0001;
    tick(3);
    ring_in = 4'b0010;
    tick(6);
    n_checks++;
    if (fault !== 1'b1 || fault_code !== 2'b10 || pos !== 2'd1 || step_seen !== 0) begin
      n_fail++;
      $display("FAIL jump_frozen: got fault=%0b code=%0d pos=%0d steps=%0d want 1 2 1 0",
               fault, fault_code, pos, step_seen);
    end
  endtask

  task automatic test_not_onehot_clear();
    reset_and_lock();
    ring_in = 4'b0010;
    tick(LAT + 1);
    ring_in = 4'b0100;
    tick(LAT + 1);
    ring_in = 4'b0110;
    tick(LAT);
    n_checks++;
    if (fault !== 1'b1 || fault_code !== 2'b01 || pos !== 2'd2) begin
      n_fail++;
      $display("FAIL not_onehot: got fault=%0b code=%0d pos=%0d want 1 1 2", fault, fault_code, pos);
    end
    ring_in = 4'b1000;
    tick(LAT + 1);
    n_checks++;
    if (fault !== 1'b1 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL fault_sticky: got fault=%0b locked=%0b want 1 0", fault, locked);
    end
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    n_checks++;
    if (fault !== 1'b0 || fault_code !== 2'b00 || locked !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_err: got fault=%0b code=%0d locked=%0b want 0 0 0",
               fault, fault_code, locked);
    end
    tick(1);
    n_checks++;
    if (locked !== 1'b1 || pos !== 2'd3) begin
      n_fail++;
      $display("FAIL relock_after_clear: got locked=%0b pos=%0d want 1 3", locked, pos);
    end
    clear_err = 1'b1;
    tick(1);
    clear_err = 1'b0;
    tick(1);
    n_checks++;
    if (locked !== 1'b1 || pos !== 2'd3 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_in_track: got locked=%0b pos=%0d fault=%0b want 1 3 0",
               locked, pos, fault);
    end
  endtask

  task automatic test_rev_wrap();
    logic [3:0] pat;
    reset_and_lock();
    for (int r = 0; r < 16; r++) begin
      for (int k = 1; k <= 4; k++) begin
        pat     = 4'b0001 << (k % 4);
        ring_in = pat;
        tick(LAT + 1);
      end
      if (r == 14) begin
        n_checks++;
        if (rev_count !== 4'd15) begin
          n_fail++;
          $display("FAIL rev_15: got rev=%0d want 15", rev_count);
        end
      end
    end
    n_checks++;
    if (rot_seen !== 16 || rev_count !== 4'd0 || step_seen !== 64 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL rev_wrap: got rots=%0d rev=%0d steps=%0d fault=%0b want 16 0 64 0",
               rot_seen, rev_count, step_seen, fault);
    end
  endtask

  task automatic test_async_reset();
    reset_and_lock();
    ring_in = 4'b0010;
    tick(LAT + 1);
    ring_in = 4'b0100;
    tick(LAT + 1);
    n_checks++;
    if (pos !== 2'd2 || locked !== 1'b1) begin
      n_fail++;
      $display("FAIL pre_reset_pos: got pos=%0d locked=%0b want 2 1", pos, locked);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    n_checks++;
    if (pos !== 2'd0 || locked !== 1'b0 || step_pulse !== 1'b0 || fault !== 1'b0) begin
      n_fail++;
      $display("FAIL async_reset: got pos=%0d locked=%0b step=%0b fault=%0b want all 0",
               pos, locked, step_pulse, fault);
    end
    ring_in = 4'b0001;
    tick(1);
    reset = 1'b0;
    tick(LAT);
    n_checks++;
    if (locked !== 1'b1 || pos !== 2'd0) begin
      n_fail++;
      $display("FAIL relock_after_reset: got locked=%0b pos=%0d want 1 0", locked, pos);
    end
  endtask

`ifdef RING_STABLE_FILTER_EN
  task automatic test_glitch_filter();
    reset_and_lock();
    ring_in = 4'b0000;
    tick(2);
    ring_in = 4'b0001;
    tick(12);
    n_checks++;
    if (fault !== 1'b0 || locked !== 1'b1 || pos !== 2'd0) begin
      n_fail++;
      $display("FAIL glitch_filter: got fault=%0b locked=%0b pos=%0d want 0 1 0", fault, locked, pos);
    end
  endtask
`endif

  initial begin
    step_seen = 0;
    rot_seen  = 0;
    test_reset();
    test_rotation();
    test_jump();
    test_not_onehot_clear();
    test_rev_wrap();
    test_async_reset();
`ifdef RING_STABLE_FILTER_EN
    test_glitch_filter();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
